// File: rtl/action_packer.sv
// rtl/action_packer.sv - reassembles a PHV from four independently timed ALU/metadata lanes.
// Each lane is a small in-order FIFO; all lanes pop together into one output register.

module action_packer_lane #(
  parameter int W     = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_next,
  output logic                     o_overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_full;
  logic          w_push;

  // A full lane still accepts a write when it pops in the same cycle.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = i_wr_en && (!w_full || i_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !i_pop)
      w_count_next = r_count + CW'(1);
    else if (!w_push && i_pop)
      w_count_next = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_overflow   = i_wr_en && w_full && !i_pop;
endmodule

module action_packer #(
  parameter int PHV_LEN    = 1124,
  parameter int width_6B   = 48,
  parameter int width_4B   = 32,
  parameter int width_2B   = 16,
  parameter int LANE_DEPTH = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic [8*width_6B-1:0]                                alu_6B_out,
  input  logic                                                 alu_6B_valid,
  input  logic [8*width_4B-1:0]                                alu_4B_out,
  input  logic                                                 alu_4B_valid,
  input  logic [8*width_2B-1:0]                                alu_2B_out,
  input  logic                                                 alu_2B_valid,
  input  logic [PHV_LEN-8*(width_6B+width_4B+width_2B)-1:0]    phv_remain_data,
  input  logic                                                 phv_remain_valid,
  output logic [PHV_LEN-1:0]                                   phv_out,
  output logic                                                 phv_out_valid,
  input  logic                                                 phv_out_ready,
  output logic                                                 stage_ready,
  output logic                                                 err_overflow
);
  localparam int W6 = 8 * width_6B;
  localparam int W4 = 8 * width_4B;
  localparam int W2 = 8 * width_2B;
  localparam int WR = PHV_LEN - W6 - W4 - W2;
  localparam int CW = $clog2(LANE_DEPTH) + 1;

  logic [W6-1:0] w_head_6;
  logic [W4-1:0] w_head_4;
  logic [W2-1:0] w_head_2;
  logic [WR-1:0] w_head_r;
  logic [CW-1:0] w_cnt_6, w_cnt_4, w_cnt_2, w_cnt_r;
  logic [CW-1:0] w_nxt_6, w_nxt_4, w_nxt_2, w_nxt_r;
  logic          w_ovf_6, w_ovf_4, w_ovf_2, w_ovf_r;
  logic          w_all_avail;
  logic          w_pop;

  logic [PHV_LEN-1:0] r_phv;
  logic               r_valid;
  logic               r_stage_ready;
  logic               r_err;

  action_packer_lane #(.W(W6), .DEPTH(LANE_DEPTH)) u_lane_6 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(alu_6B_valid), .i_wr_data(alu_6B_out), .i_pop(w_pop),
    .o_head(w_head_6), .o_count(w_cnt_6), .o_count_next(w_nxt_6), .o_overflow(w_ovf_6));

  action_packer_lane #(.W(W4), .DEPTH(LANE_DEPTH)) u_lane_4 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(alu_4B_valid), .i_wr_data(alu_4B_out), .i_pop(w_pop),
    .o_head(w_head_4), .o_count(w_cnt_4), .o_count_next(w_nxt_4), .o_overflow(w_ovf_4));

  action_packer_lane #(.W(W2), .DEPTH(LANE_DEPTH)) u_lane_2 (
    .clk(clk), .rst_n(rst_n), .i_wr_en(alu_2B_valid), .i_wr_data(alu_2B_out), .i_pop(w_pop),
    .o_head(w_head_2), .o_count(w_cnt_2), .o_count_next(w_nxt_2), .o_overflow(w_ovf_2));

  action_packer_lane #(.W(WR), .DEPTH(LANE_DEPTH)) u_lane_r (
    .clk(clk), .rst_n(rst_n), .i_wr_en(phv_remain_valid), .i_wr_data(phv_remain_data), .i_pop(w_pop),
    .o_head(w_head_r), .o_count(w_cnt_r), .o_count_next(w_nxt_r), .o_overflow(w_ovf_r));

  // Availability uses registered counts only, so a fresh write is poppable one edge later.
  assign w_all_avail = (w_cnt_6 != '0) && (w_cnt_4 != '0) && (w_cnt_2 != '0) && (w_cnt_r != '0);
  assign w_pop       = w_all_avail && (!r_valid || phv_out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phv         <= '0;
      r_valid       <= 1'b0;
      r_stage_ready <= 1'b1;
      r_err         <= 1'b0;
    end else begin
      if (w_pop) begin
        r_phv   <= {w_head_6, w_head_4, w_head_2, w_head_r};
        r_valid <= 1'b1;
      end else if (phv_out_ready) begin
        r_valid <= 1'b0;
      end
      r_err         <= r_err | w_ovf_6 | w_ovf_4 | w_ovf_2 | w_ovf_r;
      // Two free slots per lane leave room for one PHV already in flight upstream.
      r_stage_ready <= (w_nxt_6 <= CW'(LANE_DEPTH - 2)) && (w_nxt_4 <= CW'(LANE_DEPTH - 2)) &&
                       (w_nxt_2 <= CW'(LANE_DEPTH - 2)) && (w_nxt_r <= CW'(LANE_DEPTH - 2));
    end
  end

  assign phv_out       = r_phv;
  assign phv_out_valid = r_valid;
  assign stage_ready   = r_stage_ready;
  assign err_overflow  = r_err;
endmodule
